// File: rtl/fft_pkg.sv
// Shared FFT helpers: ceil-log2, twiddle scale and the rounding used
// to build the quarter-wave cosine tables at elaboration time.
package fft_pkg;

    localparam real PI = 3.14159265358979323846;

    // Ceiling log2, for v >= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Twiddle unity for a signed width w: 2^(w-2), leaving one guard bit.
    function automatic int TW_ONE(input int w);
        return 1 << (w - 2);
    endfunction

    // Round half away from zero.
    function automatic int tw_round(input real x);
        if (x >= 0.0) begin
            return $rtoi(x + 0.5);
        end
        return -$rtoi(0.5 - x);
    endfunction

    // Quarter-wave table entry c(m) = round(ONE * cos(2*pi*m/n)).
    function automatic int tw_cos(input int m, input int n, input int w);
        real a;
        a = 2.0 * PI * real'(m) / real'(n);
        return tw_round(real'(TW_ONE(w)) * $cos(a));
    endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// Quarter-wave cosine table, N/4+1 entries, with two registered reads.
// Ports: clk, rst, addr_a_i/addr_b_i (0..N/4), data_a_o/data_b_o.
import fft_pkg::*;

module twiddle_qrom #(
    parameter int N            = 256,
    parameter int bit_width_tw = 14,
    parameter int AW           = 7
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [AW-1:0]                  addr_a_i,
    input  logic [AW-1:0]                  addr_b_i,
    output logic signed [bit_width_tw-1:0] data_a_o,
    output logic signed [bit_width_tw-1:0] data_b_o
);

    localparam int Q = N / 4;
    localparam int W = bit_width_tw;

    logic signed [W-1:0] rom [0:Q];
    logic signed [W-1:0] a_q;
    logic signed [W-1:0] b_q;

    // Table is a pure constant; synthesis folds it into LUT/ROM.
    for (genvar m = 0; m <= Q; m++) begin : g_rom
        assign rom[m] = W'(tw_cos(m, N, W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= rom[addr_a_i];
            b_q <= rom[addr_b_i];
        end
    end

    assign data_a_o = a_q;
    assign data_b_o = b_q;

endmodule

// File: rtl/twiddle_gen_stage.sv
// Twiddle generator for one radix-2 SDF stage: sample counter, exponent,
// quarter-wave fold, optional IFFT sin negation; 2-cycle latency.
// Ports: clk, rst, en, start, inverse -> cos_data, sin_data, tw_valid,
// tw_index.
import fft_pkg::*;

module twiddle_gen_stage #(
    parameter int N            = 256,
    parameter int SIZE         = 8,
    parameter int STAGE        = 1,
    parameter int bit_width_tw = 14
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           start,
    input  logic                           inverse,
    output logic signed [bit_width_tw-1:0] cos_data,
    output logic signed [bit_width_tw-1:0] sin_data,
    output logic                           tw_valid,
    output logic [SIZE-1:0]                tw_index
);

    localparam int W    = bit_width_tw;
    localparam int L    = N >> (STAGE - 1);
    localparam int Q    = N / 4;
    localparam int AW   = clog2(Q + 1);

    localparam logic [SIZE-1:0] LAST   = SIZE'(L - 1);
    localparam logic [SIZE-1:0] HALF_V = SIZE'(L / 2);
    localparam logic [SIZE-1:0] ONE    = SIZE'(1);
    localparam logic [AW-1:0]   Q_A    = AW'(Q);

    // Stage 0: counter and exponent.
    logic [SIZE-1:0] cnt_q;
    logic [SIZE-1:0] cnt_d;
    logic [SIZE-1:0] k;
    logic [SIZE-1:0] e_d;

    always_comb begin
        k     = start ? '0 : cnt_q;
        cnt_d = cnt_q;
        if (en) begin
            if (start) begin
                cnt_d = ONE;
            end else if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
        // First half of each block is W^0; second half steps by 2^(STAGE-1).
        e_d = '0;
        if (k >= HALF_V) begin
            e_d = (k - HALF_V) << (STAGE - 1);
        end
    end

    logic [SIZE-1:0] e_q;
    logic            inv_q;
    logic            v_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            e_q   <= '0;
            inv_q <= 1'b0;
            v_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            v_q   <= en;
            if (en) begin
                e_q   <= e_d;
                inv_q <= inverse;
            end
        end
    end

    // ROM addresses come from e_d so the registered read lines up with e_q.
    logic [AW-1:0]       ra;
    logic [AW-1:0]       rb;
    logic signed [W-1:0] ca;
    logic signed [W-1:0] cb;

    assign ra = AW'(e_d[SIZE-3:0]);
    assign rb = Q_A - ra;

    twiddle_qrom #(
        .N            (N),
        .bit_width_tw (W),
        .AW           (AW)
    ) u_qrom (
        .clk      (clk),
        .rst      (rst),
        .addr_a_i (ra),
        .addr_b_i (rb),
        .data_a_o (ca),
        .data_b_o (cb)
    );

    // Stage 1: quadrant fold and IFFT negate.
    logic [1:0]          quad;
    logic signed [W-1:0] fc;
    logic signed [W-1:0] fs;
    logic signed [W-1:0] sn;

    assign quad = e_q[SIZE-1:SIZE-2];

    always_comb begin
        fc = ca;
        fs = cb;
        unique case (quad)
            2'd0: begin fc = ca;  fs = cb;  end
            2'd1: begin fc = -cb; fs = ca;  end
            2'd2: begin fc = -ca; fs = -cb; end
            2'd3: begin fc = cb;  fs = -ca; end
        endcase
        sn = inv_q ? -fs : fs;
    end

    logic signed [W-1:0] cos_q;
    logic signed [W-1:0] sin_q;
    logic [SIZE-1:0]     idx_q;
    logic                vld_q;

    // Outputs hold across en gaps; only tw_valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            cos_q <= '0;
            sin_q <= '0;
            idx_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= v_q;
            if (v_q) begin
                cos_q <= fc;
                sin_q <= sn;
                idx_q <= e_q;
            end
        end
    end

    assign cos_data = cos_q;
    assign sin_data = sin_q;
    assign tw_index = idx_q;
    assign tw_valid = vld_q;

endmodule

// File: tb/tb_twiddle_gen_stage.sv
// Scoreboard bench: two instances (STAGE 1 and 2) against an
// angle-based reference model.
module tb_twiddle_gen_stage;

    localparam int N    = 256;
    localparam int SIZE = 8;
    localparam int W    = 14;
    localparam real ONE = 4096.0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic start = 1'b0;
    logic inverse = 1'b0;

    logic signed [W-1:0] c1, s1, c2, s2;
    logic                v1, v2;
    logic [SIZE-1:0]     i1, i2;

    twiddle_gen_stage #(.N(N), .SIZE(SIZE), .STAGE(1), .bit_width_tw(W)) u1 (
        .clk(clk), .rst(rst), .en(en), .start(start), .inverse(inverse),
        .cos_data(c1), .sin_data(s1), .tw_valid(v1), .tw_index(i1)
    );

    twiddle_gen_stage #(.N(N), .SIZE(SIZE), .STAGE(2), .bit_width_tw(W)) u2 (
        .clk(clk), .rst(rst), .en(en), .start(start), .inverse(inverse),
        .cos_data(c2), .sin_data(s2), .tw_valid(v2), .tw_index(i2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int e;
        int c;
        int s;
        bit inv;
        int due;
    } exp_t;

    exp_t sb [2][$];
    int   pos [2];
    int   lc [2], ls [2], li [2];
    int   checks = 0;
    int   passes = 0;
    int   cyc_n = 0;
    bit   armed = 1'b0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    // Expected twiddle for sample k of a stage, from the angle directly.
    function automatic exp_t mk(input int k, input int stage,
                                input bit inv, input int due);
        exp_t r;
        int   l;
        real  a;
        l = N >> (stage - 1);
        r.e = (k < l / 2) ? 0 : (k - l / 2) * (1 << (stage - 1));
        a = 2.0 * 3.14159265358979323846 * real'(r.e) / real'(N);
        r.c = rnd(ONE * $cos(a));
        r.s = rnd(ONE * $sin(a));
        if (inv) r.s = -r.s;
        r.inv = inv;
        r.due = due;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d required %0d (t=%0t)",
                      nm, act, req, $time);
    endtask

    // Known points of W_256 for a cross-check independent of the model.
    task automatic spot(input int id, input exp_t x, input int c, input int s);
        int kc, ks;
        bit hit;
        hit = 1'b1;
        kc = 0;
        ks = 0;
        case (x.e)
            0:  begin kc = 4096;  ks = 0;    end
            32: begin kc = 2896;  ks = 2896; end
            64: begin kc = 0;     ks = 4096; end
            96: begin kc = -2896; ks = 2896; end
            default: hit = 1'b0;
        endcase
        if (hit) begin
            if (x.inv) ks = -ks;
            chk($sformatf("spot_cos%0d_e%0d", id, x.e), c, kc);
            chk($sformatf("spot_sin%0d_e%0d", id, x.e), s, ks);
        end
    endtask

    task automatic mon(input int id, input logic v, input int c,
                       input int s, input int idx);
        exp_t x;
        if (v) begin
            if (sb[id].size() == 0) begin
                chk($sformatf("unexpected_valid%0d", id), 1, 0);
            end else begin
                x = sb[id].pop_front();
                chk($sformatf("latency%0d", id), cyc_n, x.due);
                chk($sformatf("index%0d", id), idx, x.e);
                chk($sformatf("cos%0d_e%0d", id, x.e), c, x.c);
                chk($sformatf("sin%0d_e%0d", id, x.e), s, x.s);
                spot(id, x, c, s);
                lc[id] = c;
                ls[id] = s;
                li[id] = idx;
            end
        end else begin
            chk($sformatf("hold_cos%0d", id), c, lc[id]);
            chk($sformatf("hold_sin%0d", id), s, ls[id]);
            chk($sformatf("hold_idx%0d", id), idx, li[id]);
            if (sb[id].size() != 0 && sb[id][0].due <= cyc_n) begin
                void'(sb[id].pop_front());
                chk($sformatf("missing_valid%0d", id), 0, 1);
            end
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (armed) begin
            mon(0, v1, int'(c1), int'(s1), int'(i1));
            mon(1, v2, int'(c2), int'(s2), int'(i2));
        end
    end

    task automatic cyc(input bit e_, input bit s_, input bit inv_);
        int k;
        int l;
        @(negedge clk);
        en = e_;
        start = s_;
        inverse = inv_;
        if (e_) begin
            for (int d = 0; d < 2; d++) begin
                l = N >> d;
                k = s_ ? 0 : pos[d];
                pos[d] = (k + 1) % l;
                sb[d].push_back(mk(k, d + 1, inv_, cyc_n + 2));
            end
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        en = 1'b1;
        start = 1'b1;
        for (int d = 0; d < 2; d++) begin
            sb[d].delete();
            pos[d] = 0;
            lc[d] = 0;
            ls[d] = 0;
            li[d] = 0;
        end
        repeat (n) begin
            @(posedge clk);
            #2;
            chk("rst_cos", int'(c1) | int'(c2), 0);
            chk("rst_sin", int'(s1) | int'(s2), 0);
            chk("rst_valid", int'(v1) | int'(v2), 0);
            chk("rst_idx", int'(i1) | int'(i2), 0);
        end
        armed = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        en = 1'b0;
        start = 1'b0;
    endtask

    bit inv_r;

    initial begin
        do_reset(3);
        cyc(1, 0, 0);
        repeat (4) cyc(0, 0, 0);
        cyc(1, 1, 0);
        repeat (259) cyc(1, 0, 0);
        repeat (3) cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        repeat (3) cyc(0, 0, 0);
        cyc(1, 1, 1);
        repeat (199) cyc(1, 0, 1);
        repeat (56) cyc(1, 0, 0);
        cyc(1, 1, 0);
        repeat (99) cyc(1, 0, 0);
        cyc(1, 1, 0);
        repeat (6) cyc(1, 0, 0);
        cyc(1, 1, 0);
        repeat (199) cyc(1, 0, 0);
        do_reset(1);
        repeat (6) cyc(1, 0, 0);
        inv_r = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(15) == 0) inv_r = ~inv_r;
            if ($urandom_range(399) == 0) begin
                do_reset(1);
            end else begin
                cyc($urandom_range(3) != 0, $urandom_range(99) == 0, inv_r);
            end
        end
        repeat (5) cyc(0, 0, 0);
        chk("drain0", sb[0].size(), 0);
        chk("drain1", sb[1].size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
